triggered_capture_buffer: RTL and testbench

//  Laser-triggered ADC snapshot buffer: records packed ADC beats continuously into a circular RAM,

---
 rtl/triggered_capture_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_triggered_capture_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triggered_capture_buffer.sv
// Triggered ADC snapshot buffer: records packed ADC beats into a circular RAM and freezes a pre/post-trigger window.
// The frozen window is then streamed out one sign-extended sample per AXIS beat.
// Build macro CAPTURE_HEADER_EN adds one leading sequence-number beat to every dump.
module triggered_capture_buffer #(
  parameter int SAMPLE_WIDTH           = 16,
  parameter int SAMPLES_PER_BEAT       = 8,
  parameter int C_S00_AXIS_TDATA_WIDTH = 128,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int DEPTH_BEATS            = 128,
  parameter int PRE_BEATS              = 16
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                laser_trigger,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  output logic                                capture_busy,
  output logic                                trigger_dropped
);

  localparam int IN_W       = C_S00_AXIS_TDATA_WIDTH;
  localparam int OUT_W      = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW         = $clog2(DEPTH_BEATS);
  localparam int CW         = AW + 1;
  localparam int SIW        = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;
  localparam int POST_BEATS = DEPTH_BEATS - PRE_BEATS;

  localparam logic [CW-1:0]  PRE_LAST   = CW'(PRE_BEATS - 1);
  localparam logic [CW-1:0]  POST_LAST  = CW'(POST_BEATS - 1);
  localparam logic [CW-1:0]  DEPTH_CNT  = CW'(DEPTH_BEATS);
  localparam logic [CW-1:0]  DEPTH_LAST = CW'(DEPTH_BEATS - 1);
  localparam logic [AW-1:0]  PRE_OFS    = AW'(PRE_BEATS);
  localparam logic [SIW-1:0] SAMP_LAST  = SIW'(SAMPLES_PER_BEAT - 1);

  typedef enum logic [1:0] {ARMING, ARMED, FILLING, DUMPING} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             fill_cnt, rd_cnt;
  logic                      laser_trigger_q, trig_edge, in_accept;
  logic                      trig_drop, capture_start, dump_done;
  logic [IN_W-1:0]           mem [DEPTH_BEATS];
  logic [IN_W-1:0]           rd_data, cur_beat;
  logic                      rd_valid, rd_last, cur_valid, cur_last;
  logic [SIW-1:0]            samp_idx;
  logic                      out_free, hdr_load, samp_load, samp_last, cur_load, rd_issue;
  logic [OUT_W-1:0]          hdr_word, samp_ext;
  logic signed [SAMPLE_WIDTH-1:0] samp;
  logic                      unused_inputs;

  assign s00_axis_tready = (state_q != DUMPING);
  assign capture_busy    = (state_q == FILLING) || (state_q == DUMPING);
  assign m00_axis_tstrb  = '1;
  assign in_accept       = s00_axis_tvalid & s00_axis_tready;
  assign trig_edge       = laser_trigger & ~laser_trigger_q;
  assign unused_inputs   = ^{s00_axis_tstrb, s00_axis_tlast};

  always_comb begin
    state_d       = state_q;
    trig_drop     = 1'b0;
    capture_start = 1'b0;
    dump_done     = 1'b0;
    case (state_q)
      ARMING: begin
        trig_drop = trig_edge;
        if (in_accept && fill_cnt == PRE_LAST)
          state_d = ARMED;
      end
      ARMED: begin
        // The beat accepted alongside the edge already counts as post-trigger beat 0
        if (trig_edge) begin
          capture_start = 1'b1;
          if (in_accept && POST_BEATS == 1)
            state_d = DUMPING;
          else
            state_d = FILLING;
        end
      end
      FILLING: begin
        trig_drop = trig_edge;
        if (in_accept && fill_cnt == POST_LAST)
          state_d = DUMPING;
      end
      DUMPING: begin
        trig_drop = trig_edge;
        if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
          dump_done = 1'b1;
          state_d   = ARMING;
        end
      end
      default: state_d = ARMING;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn)
      state_q <= ARMING;
    else
      state_q <= state_d;
  end

  // fill_cnt counts pre-trigger beats while arming and post-trigger beats while filling
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      laser_trigger_q <= 1'b0;
      trigger_dropped <= 1'b0;
      wr_ptr          <= '0;
      fill_cnt        <= '0;
      rd_ptr          <= '0;
      rd_cnt          <= '0;
    end else begin
      laser_trigger_q <= laser_trigger;
      trigger_dropped <= trig_drop;
      if (in_accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (capture_start)
        fill_cnt <= in_accept ? CW'(1) : '0;
      else if (dump_done)
        fill_cnt <= '0;
      else if (in_accept && (state_q == ARMING || state_q == FILLING))
        fill_cnt <= fill_cnt + CW'(1);
      if (capture_start) begin
        rd_ptr <= wr_ptr - PRE_OFS;
        rd_cnt <= '0;
      end else if (rd_issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (in_accept)
      mem[wr_ptr] <= s00_axis_tdata;
    if (rd_issue)
      rd_data <= mem[rd_ptr];
  end

  // Three-stage drain: RAM output register, beat being unpacked, AXIS output register
  assign out_free  = ~m00_axis_tvalid | m00_axis_tready;
  assign samp_load = (state_q == DUMPING) & out_free & cur_valid & ~hdr_load;
  assign samp_last = (samp_idx == SAMP_LAST);
  assign cur_load  = rd_valid & (~cur_valid | (samp_load & samp_last));
  assign rd_issue  = (state_q == DUMPING) & (rd_cnt != DEPTH_CNT) & (~rd_valid | cur_load);
  assign samp      = cur_beat[SAMPLE_WIDTH-1:0];
  assign samp_ext  = OUT_W'(samp);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      cur_valid <= 1'b0;
      cur_last  <= 1'b0;
      cur_beat  <= '0;
      samp_idx  <= '0;
    end else begin
      if (rd_issue) begin
        rd_valid <= 1'b1;
        rd_last  <= (rd_cnt == DEPTH_LAST);
      end else if (cur_load) begin
        rd_valid <= 1'b0;
      end
      if (cur_load) begin
        cur_valid <= 1'b1;
        cur_beat  <= rd_data;
        cur_last  <= rd_last;
        samp_idx  <= '0;
      end else if (samp_load) begin
        cur_beat <= cur_beat >> SAMPLE_WIDTH;
        samp_idx <= samp_idx + SIW'(1);
        if (samp_last)
          cur_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else if (hdr_load) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= hdr_word;
      m00_axis_tlast  <= 1'b0;
    end else if (samp_load) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= samp_ext;
      m00_axis_tlast  <= cur_last & samp_last;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end
  end

`ifdef CAPTURE_HEADER_EN
  logic        hdr_pending;
  logic [15:0] capture_seq;

  // Sequence number advances only when a dump completes, so aborted captures do not consume one
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      hdr_pending <= 1'b0;
      capture_seq <= '0;
    end else begin
      if (capture_start)
        hdr_pending <= 1'b1;
      else if (hdr_load)
        hdr_pending <= 1'b0;
      if (dump_done)
        capture_seq <= capture_seq + 16'd1;
    end
  end

  assign hdr_load = (state_q == DUMPING) & hdr_pending & out_free;
  assign hdr_word = OUT_W'(capture_seq);
`else
  assign hdr_load = 1'b0;
  assign hdr_word = '0;
`endif

endmodule

// File: tb/tb_triggered_capture_buffer.sv
// Directed bench for triggered_capture_buffer (DEPTH_BEATS=8, PRE_BEATS=2, 4 samples of 16 bits per beat).
`timescale 1ns/1ps
module tb_triggered_capture_buffer;
  localparam int SW    = 16;
  localparam int SPB   = 4;
  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int DEPTH = 8;
  localparam int PRE   = 2;
  localparam int NOUT  = DEPTH * SPB;
`ifdef CAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int MAXOUT = NOUT + HDR;

  logic              clk = 1'b0;
  logic              s00_axis_aresetn;
  logic              s00_axis_tvalid;
  logic [IN_W-1:0]   s00_axis_tdata;
  logic [IN_W/8-1:0] s00_axis_tstrb;
  logic              s00_axis_tlast;
  logic              s00_axis_tready;
  logic              laser_trigger;
  logic              m00_axis_tready;
  logic              m00_axis_tvalid;
  logic [OUT_W-1:0]  m00_axis_tdata;
  logic [OUT_W/8-1:0] m00_axis_tstrb;
  logic              m00_axis_tlast;
  logic              capture_busy;
  logic              trigger_dropped;

  triggered_capture_buffer #(
    .SAMPLE_WIDTH(SW), .SAMPLES_PER_BEAT(SPB), .C_S00_AXIS_TDATA_WIDTH(IN_W),
    .C_M00_AXIS_TDATA_WIDTH(OUT_W), .DEPTH_BEATS(DEPTH), .PRE_BEATS(PRE)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(s00_axis_aresetn),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata),
    .s00_axis_tstrb(s00_axis_tstrb), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready), .laser_trigger(laser_trigger),
    .m00_axis_tready(m00_axis_tready), .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tlast(m00_axis_tlast), .capture_busy(capture_busy),
    .trigger_dropped(trigger_dropped)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] out_data [0:63];
  int   n_out, last_count, last_pos, beats_accepted, dropped_count;
  int   stall_bad, ready_in_dump, first_latency, post_active, timed_out;
  logic abort_tvalid, abort_tready, abort_busy;

  function automatic logic [IN_W-1:0] beat_data(input int b, input int neg_k);
    logic [IN_W-1:0] d;
    int k;
    d = '0;
    for (int i = 0; i < SPB; i++) begin
      k = b * SPB + i;
      d[i*SW +: SW] = (k == neg_k) ? 16'h8000 : 16'(k);
    end
    return d;
  endfunction

  task automatic do_reset();
    s00_axis_aresetn = 1'b0;
    s00_axis_tvalid  = 1'b0;
    s00_axis_tdata   = '0;
    laser_trigger    = 1'b0;
    m00_axis_tready  = 1'b1;
    repeat (2) @(negedge clk);
    s00_axis_aresetn = 1'b1;
  endtask

  // Streams ramp beats, fires the trigger on beat trig_beat and records the output stream.
  task automatic apply_stimulus(input int trig_beat, input bit rnd_ready, input bit early_trig,
                                input bit dump_trig, input int neg_k, input int abort_at);
    int beat, cyc, trig_hold, dump_cyc, post_cyc;
    bit trig_started, main_done, aborted, dump_pulsed, prev_stall;
    logic [31:0] prev_data;
    beat = 0; cyc = 0; trig_hold = 0; dump_cyc = -1; post_cyc = 0;
    trig_started = 0; main_done = 0; aborted = 0; dump_pulsed = 0; prev_stall = 0;
    prev_data = '0;
    n_out = 0; last_count = 0; last_pos = -1; beats_accepted = -1; dropped_count = 0;
    stall_bad = 0; ready_in_dump = 0; first_latency = -1; post_active = 0; timed_out = 0;
    for (int i = 0; i < 64; i++) out_data[i] = '0;
    while (!aborted && post_cyc < 20 && cyc < 800) begin
      @(negedge clk);
      if (abort_at >= 0 && n_out == abort_at) begin
        s00_axis_aresetn = 1'b0;
        @(negedge clk);
        abort_tvalid = m00_axis_tvalid;
        abort_tready = s00_axis_tready;
        abort_busy   = capture_busy;
        aborted      = 1;
      end else begin
        if (trigger_dropped) dropped_count++;
        if (main_done) begin
          if (m00_axis_tvalid || capture_busy) post_active++;
          post_cyc++;
        end
        if (!s00_axis_tready && dump_cyc < 0) dump_cyc = cyc;
        if (m00_axis_tvalid && first_latency < 0) first_latency = cyc - dump_cyc;
        if (m00_axis_tvalid && s00_axis_tready) ready_in_dump++;
        if (prev_stall && m00_axis_tdata !== prev_data) stall_bad++;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = beat_data(beat, neg_k);
        if (!trig_started && beat == trig_beat && s00_axis_tready) begin
          trig_started = 1;
          trig_hold    = 3;
        end
        laser_trigger = (trig_hold > 0) || (early_trig && cyc == 0);
        if (trig_hold > 0) trig_hold--;
        if (dump_trig && !dump_pulsed && m00_axis_tvalid) begin
          laser_trigger = 1'b1;
          dump_pulsed   = 1;
        end
        m00_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m00_axis_tvalid && m00_axis_tready && !main_done) begin
          if (n_out < 64) out_data[n_out] = m00_axis_tdata;
          if (m00_axis_tlast) begin
            last_count++;
            last_pos       = n_out;
            main_done      = 1;
            beats_accepted = beat;
          end
          n_out++;
        end
        prev_stall = m00_axis_tvalid && !m00_axis_tready;
        prev_data  = m00_axis_tdata;
        if (s00_axis_tvalid && s00_axis_tready) beat++;
        cyc++;
      end
    end
    if (!aborted && !main_done) timed_out = 1;
    s00_axis_tvalid = 1'b0;
    laser_trigger   = 1'b0;
    m00_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    s00_axis_aresetn = 1'b0;
    s00_axis_tvalid  = 1'b0;
    s00_axis_tdata   = '0;
    laser_trigger    = 1'b0;
    m00_axis_tready  = 1'b0;
    @(negedge clk);
    checks++; if (s00_axis_tready !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_tready: got %b expected 1", s00_axis_tready); end
    checks++; if (m00_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_tvalid: got %b expected 0", m00_axis_tvalid); end
    checks++; if (m00_axis_tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_tlast: got %b expected 0", m00_axis_tlast); end
    checks++; if (m00_axis_tdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_m_tdata: got %h expected 00000000", m00_axis_tdata); end
    checks++; if (m00_axis_tstrb !== 4'hF) begin failures++; $display("[TB] FAIL reset_m_tstrb: got %h expected f", m00_axis_tstrb); end
    checks++; if (capture_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", capture_busy); end
    checks++; if (trigger_dropped !== 1'b0) begin failures++; $display("[TB] FAIL reset_dropped: got %b expected 0", trigger_dropped); end
    @(negedge clk);
    s00_axis_aresetn = 1'b1;
    m00_axis_tready  = 1'b1;
    @(negedge clk);
    checks++; if (m00_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL idle_m_tvalid: got %b expected 0", m00_axis_tvalid); end
  endtask

  task automatic test_ramp(input bit rnd_ready);
    do_reset();
    apply_stimulus(10, rnd_ready, 0, 0, -1, -1);
    checks++; if (timed_out !== 0) begin failures++; $display("[TB] FAIL ramp_timeout: got %0d expected 0", timed_out); end
    checks++; if (n_out !== MAXOUT) begin failures++; $display("[TB] FAIL ramp_count: got %0d expected %0d", n_out, MAXOUT); end
    for (int j = 0; j < NOUT; j++) begin
      checks++;
      if (out_data[HDR+j] !== 32'(32 + j)) begin
        failures++; $display("[TB] FAIL ramp_data[%0d]: got %h expected %h", j, out_data[HDR+j], 32'(32 + j));
      end
    end
    checks++; if (last_count !== 1) begin failures++; $display("[TB] FAIL ramp_tlast_count: got %0d expected 1", last_count); end
    checks++; if (last_pos !== MAXOUT - 1) begin failures++; $display("[TB] FAIL ramp_tlast_pos: got %0d expected %0d", last_pos, MAXOUT - 1); end
    checks++; if (ready_in_dump !== 0) begin failures++; $display("[TB] FAIL ramp_s_tready_in_dump: got %0d expected 0", ready_in_dump); end
    checks++; if (beats_accepted !== 16) begin failures++; $display("[TB] FAIL ramp_beats_in: got %0d expected 16", beats_accepted); end
    checks++; if (dropped_count !== 0) begin failures++; $display("[TB] FAIL ramp_dropped: got %0d expected 0", dropped_count); end
    checks++; if (first_latency < 0 || first_latency > 3) begin failures++; $display("[TB] FAIL ramp_first_valid_latency: got %0d expected 0..3", first_latency); end
    checks++; if (post_active !== 0) begin failures++; $display("[TB] FAIL ramp_post_activity: got %0d expected 0", post_active); end
    checks++; if (stall_bad !== 0) begin failures++; $display("[TB] FAIL ramp_stall_stability: got %0d expected 0", stall_bad); end
  endtask

  task automatic test_drop_and_negative();
    do_reset();
    apply_stimulus(5, 0, 1, 1, 17, -1);
    checks++; if (dropped_count !== 2) begin failures++; $display("[TB] FAIL drop_count: got %0d expected 2", dropped_count); end
    checks++; if (n_out !== MAXOUT) begin failures++; $display("[TB] FAIL drop_out_count: got %0d expected %0d", n_out, MAXOUT); end
    checks++; if (out_data[HDR+5] !== 32'hFFFF8000) begin failures++; $display("[TB] FAIL negative_sample: got %h expected ffff8000", out_data[HDR+5]); end
    checks++; if (out_data[HDR+0] !== 32'd12) begin failures++; $display("[TB] FAIL drop_first: got %h expected 0000000c", out_data[HDR+0]); end
    checks++; if (out_data[HDR+NOUT-1] !== 32'd43) begin failures++; $display("[TB] FAIL drop_final: got %h expected 0000002b", out_data[HDR+NOUT-1]); end
    checks++; if (last_count !== 1) begin failures++; $display("[TB] FAIL drop_tlast_count: got %0d expected 1", last_count); end
    checks++; if (post_active !== 0) begin failures++; $display("[TB] FAIL drop_extra_capture: got %0d expected 0", post_active); end
  endtask

  task automatic test_wrap_and_abort();
    do_reset();
    apply_stimulus(21, 0, 0, 0, -1, -1);
    checks++; if (n_out !== MAXOUT) begin failures++; $display("[TB] FAIL wrap_count: got %0d expected %0d", n_out, MAXOUT); end
    for (int j = 0; j < NOUT; j++) begin
      checks++;
      if (out_data[HDR+j] !== 32'(76 + j)) begin
        failures++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", j, out_data[HDR+j], 32'(76 + j));
      end
    end
    do_reset();
    apply_stimulus(21, 0, 0, 0, -1, 5);
    for (int j = HDR; j < 5; j++) begin
      checks++;
      if (out_data[j] !== 32'(76 + j - HDR)) begin
        failures++; $display("[TB] FAIL abort_data[%0d]: got %h expected %h", j, out_data[j], 32'(76 + j - HDR));
      end
    end
    checks++; if (abort_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL abort_tvalid: got %b expected 0", abort_tvalid); end
    checks++; if (abort_tready !== 1'b1) begin failures++; $display("[TB] FAIL abort_s_tready: got %b expected 1", abort_tready); end
    checks++; if (abort_busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", abort_busy); end
    s00_axis_aresetn = 1'b1;
    @(negedge clk);
    apply_stimulus(10, 0, 0, 0, -1, -1);
    checks++; if (n_out !== MAXOUT) begin failures++; $display("[TB] FAIL recover_count: got %0d expected %0d", n_out, MAXOUT); end
    for (int j = 0; j < NOUT; j++) begin
      checks++;
      if (out_data[HDR+j] !== 32'(32 + j)) begin
        failures++; $display("[TB] FAIL recover_data[%0d]: got %h expected %h", j, out_data[HDR+j], 32'(32 + j));
      end
    end
    checks++; if (last_pos !== MAXOUT - 1) begin failures++; $display("[TB] FAIL recover_tlast_pos: got %0d expected %0d", last_pos, MAXOUT - 1); end
  endtask

`ifdef CAPTURE_HEADER_EN
  task automatic test_header();
    do_reset();
    apply_stimulus(10, 0, 0, 0, -1, -1);
    checks++; if (out_data[0] !== 32'd0) begin failures++; $display("[TB] FAIL header_first: got %h expected 00000000", out_data[0]); end
    checks++; if (out_data[1] !== 32'd32) begin failures++; $display("[TB] FAIL header_first_sample: got %h expected 00000020", out_data[1]); end
    apply_stimulus(10, 0, 0, 0, -1, -1);
    checks++; if (out_data[0] !== 32'd1) begin failures++; $display("[TB] FAIL header_second: got %h expected 00000001", out_data[0]); end
    checks++; if (n_out !== NOUT + 1) begin failures++; $display("[TB] FAIL header_second_count: got %0d expected %0d", n_out, NOUT + 1); end
    checks++; if (out_data[NOUT] !== 32'd63) begin failures++; $display("[TB] FAIL header_second_last: got %h expected 0000003f", out_data[NOUT]); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    s00_axis_tstrb = '1;
    s00_axis_tlast = 1'b0;
    test_reset();
    test_ramp(0);
    test_ramp(1);
    test_drop_and_negative();
    test_wrap_and_abort();
`ifdef CAPTURE_HEADER_EN
    test_header();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
